// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: register map, CTRL/STATUS bit indices and fill FSM states
// shared by the VGA frame-buffer blitter and its cursor stepper.
package vga_fb_pkg;

  localparam logic [2:0] REG_X        = 3'd0;
  localparam logic [2:0] REG_Y        = 3'd1;
  localparam logic [2:0] REG_PIXEL    = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_FILL_LEN = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  localparam int CTRL_AUTOINC = 0;
  localparam int CTRL_FILL_GO = 1;
  localparam int STATUS_BUSY  = 0;

  localparam int NUM_REGS = 6;

  typedef enum logic {
    IDLE,
    FILL
  } fill_state_e;

endpackage

// File: rtl/vga_xy_stepper.sv
// vga_xy_stepper: combinational next cursor position. X wraps to 0 at the
// last column and carries into Y, which wraps to 0 at the last row.
module vga_xy_stepper #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y
);
  import vga_fb_pkg::*;

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

  // Step one column; anything at or past the last column wraps.
  always_comb begin
    o_x = i_x + 1'b1;
    o_y = i_y;
    if (i_x >= X_LAST) begin
      o_x = '0;
      o_y = (i_y >= Y_LAST) ? '0 : i_y + 1'b1;
    end
  end

endmodule

// File: rtl/vga_fb_blitter.sv
// vga_fb_blitter: CPU-bus plot/fill engine for frame buffer port A.
// Define VGA_YFLIP_EN to present rows bottom-up (row 0 at screen bottom).
module vga_fb_blitter
  import vga_fb_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120,
  parameter int PIXEL_W = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [7:0]           BUS_ADDR,
  inout  wire  [7:0]           BUS_DATA,
  input  logic                 BUS_WE,
  output logic [X_W+Y_W-1:0]   FB_ADDR,
  output logic [PIXEL_W-1:0]   FB_DATA_OUT,
  output logic                 FB_WE,
  input  logic [PIXEL_W-1:0]   FB_DATA_IN
);

  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [PIXEL_W-1:0] r_colour;
  logic               r_autoinc;
  logic [7:0]         r_fill_len;
  fill_state_e        r_state;
  logic [X_W-1:0]     r_fx;
  logic [Y_W-1:0]     r_fy;
  logic [7:0]         r_remain;
  logic               r_rd_en;
  logic [7:0]         r_rd_data;

  logic [7:0]         w_off;
  logic               w_in_range;
  logic [2:0]         w_reg;
  logic               w_wr;
  logic               w_rd;
  logic [PIXEL_W-1:0] w_pix;
  logic [X_W-1:0]     w_nx;
  logic [Y_W-1:0]     w_ny;
  logic [X_W-1:0]     w_fnx;
  logic [Y_W-1:0]     w_fny;
  logic [7:0]         w_rd_val;
  logic               w_busy;

  function automatic logic in_view(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    return (int'(x) < X_MAX) && (int'(y) < Y_MAX);
  endfunction

  function automatic logic [Y_W-1:0] fb_row(
    input logic [Y_W-1:0] y
  );
`ifdef VGA_YFLIP_EN
    return Y_W'(Y_MAX - 1) - y;
`else
    return y;
`endif
  endfunction

  assign w_off      = BUS_ADDR - BASE_ADDR;
  assign w_in_range = (BUS_ADDR >= BASE_ADDR) &&
                      (w_off < 8'(NUM_REGS));
  assign w_reg      = w_off[2:0];
  assign w_busy     = (r_state == FILL);
  assign w_wr       = BUS_WE && w_in_range && !w_busy;
  assign w_rd       = !BUS_WE && w_in_range;
  assign w_pix      = BUS_DATA[PIXEL_W-1:0];

  vga_xy_stepper #(
    .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) u_step_cur (
    .i_x(r_x), .i_y(r_y), .o_x(w_nx), .o_y(w_ny)
  );

  vga_xy_stepper #(
    .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) u_step_fill (
    .i_x(r_fx), .i_y(r_fy), .o_x(w_fnx), .o_y(w_fny)
  );

  // Register decode, plot and run-fill FSM with registered FB outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_x         <= '0;
      r_y         <= '0;
      r_colour    <= '0;
      r_autoinc   <= 1'b0;
      r_fill_len  <= '0;
      r_state     <= IDLE;
      r_fx        <= '0;
      r_fy        <= '0;
      r_remain    <= '0;
      FB_WE       <= 1'b0;
      FB_ADDR     <= '0;
      FB_DATA_OUT <= '0;
    end else begin
      FB_WE   <= 1'b0;
      FB_ADDR <= {fb_row(r_y), r_x};
      unique case (r_state)
        IDLE: begin
          if (w_wr) begin
            unique case (w_reg)
              REG_X: r_x <= BUS_DATA[X_W-1:0];
              REG_Y: r_y <= BUS_DATA[Y_W-1:0];
              REG_PIXEL: begin
                r_colour    <= w_pix;
                FB_DATA_OUT <= w_pix;
                FB_WE       <= in_view(r_x, r_y);
                if (r_autoinc) begin
                  r_x <= w_nx;
                  r_y <= w_ny;
                end
              end
              REG_CTRL: begin
                r_autoinc <= BUS_DATA[CTRL_AUTOINC];
                if (BUS_DATA[CTRL_FILL_GO] && r_fill_len != 8'd0) begin
                  r_state     <= FILL;
                  FB_WE       <= in_view(r_x, r_y);
                  FB_DATA_OUT <= r_colour;
                  r_fx        <= w_nx;
                  r_fy        <= w_ny;
                  r_remain    <= r_fill_len - 8'd1;
                end
              end
              REG_FILL_LEN: r_fill_len <= BUS_DATA;
              default: ;
            endcase
          end
        end
        FILL: begin
          if (r_remain != 8'd0) begin
            FB_ADDR  <= {fb_row(r_fy), r_fx};
            FB_WE    <= in_view(r_fx, r_fy);
            r_fx     <= w_fnx;
            r_fy     <= w_fny;
            r_remain <= r_remain - 8'd1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Readback mux; PIXEL returns frame buffer data at the idle {Y,X} address.
  always_comb begin
    w_rd_val = '0;
    unique case (w_reg)
      REG_X:        w_rd_val = 8'(r_x);
      REG_Y:        w_rd_val = 8'(r_y);
      REG_PIXEL:    w_rd_val = 8'(FB_DATA_IN);
      REG_CTRL:     w_rd_val[CTRL_AUTOINC] = r_autoinc;
      REG_FILL_LEN: w_rd_val = r_fill_len;
      REG_STATUS:   w_rd_val[STATUS_BUSY] = w_busy;
      default:      w_rd_val = '0;
    endcase
  end

  // Registered read data and bus driver enable, one cycle after the request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_en   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_en <= w_rd;
      if (w_rd) r_rd_data <= w_rd_val;
    end
  end

  assign BUS_DATA = r_rd_en ? r_rd_data : 8'bz;

endmodule

// File: tb/tb_vga_fb_blitter.sv
// tb_vga_fb_blitter: directed and random checks of the VGA blitter against
// a pixel-level model of cursor, plot and fill behaviour.
module tb_vga_fb_blitter;

  localparam logic [7:0] BASE = 8'hB0;
  localparam int XM = 160;
  localparam int YM = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bus_addr;
  logic        bus_we;
  tri1  [7:0]  bus_data;
  logic        r_drv;
  logic [7:0]  r_dout;
  logic [14:0] fb_addr;
  logic        fb_dout;
  logic        fb_we;
  logic        fb_din;

  assign bus_data = r_drv ? r_dout : 8'bz;

  always #5 clk = ~clk;

  vga_fb_blitter dut (
    .CLK(clk), .RESET(rst), .BUS_ADDR(bus_addr), .BUS_DATA(bus_data),
    .BUS_WE(bus_we), .FB_ADDR(fb_addr), .FB_DATA_OUT(fb_dout),
    .FB_WE(fb_we), .FB_DATA_IN(fb_din)
  );

  logic fbm [0:32767];
  always @(posedge clk) begin
    if (fb_we) fbm[fb_addr] <= fb_dout;
    fb_din <= fbm[fb_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] obs_q[$];
  int          obs_cyc[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fb_we) begin
    obs_q.push_back({fb_addr, fb_dout});
    obs_cyc.push_back(cyc);
  end

  int  m_x, m_y, m_len;
  bit  m_col, m_ai;
  bit  m_mem [0:XM*YM-1];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] exp_addr(int x, int y);
    logic [6:0] row;
`ifdef VGA_YFLIP_EN
    row = 7'(YM - 1 - y);
`else
    row = 7'(y);
`endif
    return {row, 8'(x)};
  endfunction

  function automatic bit vis(int x, int y);
    return x < XM && y < YM;
  endfunction

  task automatic step(inout int x, inout int y);
    x = x + 1;
    if (x >= XM) begin
      x = 0;
      y = y + 1;
      if (y >= YM) y = 0;
    end
  endtask

  task automatic m_put(int x, int y);
    if (vis(x, y)) begin
      exp_q.push_back({exp_addr(x, y), m_col});
      m_mem[y*XM + x] = m_col;
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(int off, logic [7:0] d);
    bus_addr = BASE + 8'(off);
    bus_we = 1'b1;
    r_drv = 1'b1;
    r_dout = d;
    @(negedge clk);
    bus_we = 1'b0;
    r_drv = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic bus_rd(logic [7:0] a, output logic [7:0] d);
    bus_addr = a;
    bus_we = 1'b0;
    @(negedge clk);
    d = bus_data;
    bus_addr = 8'h00;
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    bus_addr = BASE + 8'd5;
    bus_we = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_data[0] !== 1'b1) break;
      busy++;
    end
    bus_addr = 8'h00;
  endtask

  task automatic drain(string tag, bit consec);
    check({tag, "_n"}, obs_q.size(), exp_q.size());
    if (consec && obs_cyc.size() > 1)
      check({tag, "_gap"}, obs_cyc[$] - obs_cyc[0], obs_cyc.size() - 1);
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_wr(int off, logic [7:0] d, bit hold = 0);
    int cx, cy, b, len;
    bit go;
    go = 0;
    len = m_len;
    bus_wr(off, d);
    case (off)
      0: m_x = int'(d);
      1: m_y = int'(d[6:0]);
      2: begin
        m_col = d[0];
        m_put(m_x, m_y);
        if (m_ai) step(m_x, m_y);
      end
      3: begin
        m_ai = d[0];
        if (d[1] && m_len != 0) begin
          go = 1;
          cx = m_x;
          cy = m_y;
          for (int i = 0; i < m_len; i++) begin
            m_put(cx, cy);
            step(cx, cy);
          end
        end
      end
      4: m_len = int'(d);
      default: ;
    endcase
    if (go && !hold) begin
      wait_idle(b);
      check("busy_len", b, len);
    end
  endtask

  task automatic do_rd(int off, string tag);
    logic [7:0] d, e;
    idle(2);
    case (off)
      0: e = 8'(m_x);
      1: e = 8'(m_y);
      2: e = vis(m_x, m_y) ? 8'(m_mem[m_y*XM + m_x]) : 8'd0;
      3: e = {7'd0, m_ai};
      4: e = 8'(m_len);
      default: e = 8'd0;
    endcase
    bus_rd(BASE + 8'(off), d);
    check(tag, d, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    m_x = 0; m_y = 0; m_col = 0; m_ai = 0; m_len = 0;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    int b, op;
    bus_addr = 8'h00; bus_we = 1'b0; r_drv = 1'b0; r_dout = 8'h00;
    for (int i = 0; i < 32768; i++) fbm[i] = 1'b0;
    for (int i = 0; i < XM*YM; i++) m_mem[i] = 1'b0;
    do_reset();
    idle(1);

    check("rst_we", fb_we, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_dout", fb_dout, 0);
    check("rst_busz", bus_data, 8'hFF);
    for (int o = 0; o < 6; o++) do_rd(o, "rst_reg");

    do_wr(0, 8'd5);
    do_wr(1, 8'd3);
    do_wr(2, 8'd1);
    check("plot_we", fb_we, 1);
    check("plot_addr", fb_addr, exp_addr(5, 3));
    check("plot_dout", fb_dout, 1);
    @(negedge clk);
    check("plot_we_off", fb_we, 0);
    idle(1);
    drain("plot", 0);
    do_rd(0, "plot_x");
    do_rd(2, "plot_rd");

`ifdef VGA_YFLIP_EN
    do_wr(1, 8'd0);
    do_wr(2, 8'd1);
    check("flip_row", fb_addr[14:8], 119);
    idle(2);
    drain("flip", 0);
`endif

    do_wr(3, 8'h01);
    do_wr(0, 8'd159);
    do_wr(1, 8'd119);
    do_wr(2, 8'd1);
    do_wr(2, 8'd0);
    idle(2);
    drain("ai", 0);
    do_rd(0, "ai_x");
    do_rd(1, "ai_y");
    do_wr(3, 8'h00);

    do_wr(2, 8'd1);
    idle(2);
    drain("col", 0);
    do_wr(0, 8'd158);
    do_wr(1, 8'd10);
    do_wr(4, 8'd4);
    do_wr(3, 8'h02);
    idle(2);
    drain("fill", 1);
    for (int o = 0; o < 6; o++) do_rd(o, "fill_reg");

    do_wr(0, 8'd200);
    do_wr(2, 8'd1);
    idle(3);
    drain("oor", 0);
    do_wr(4, 8'd0);
    do_wr(3, 8'h02);
    bus_rd(BASE + 8'd5, d);
    check("len0_busy", d, 0);
    idle(3);
    drain("len0", 0);
    bus_rd(BASE + 8'd6, d);
    check("rd_oor_z", bus_data, 8'hFF);

    do_wr(0, 8'd20);
    do_wr(1, 8'd40);
    do_wr(4, 8'd50);
    do_wr(3, 8'h02, 1);
    bus_wr(0, 8'd0);
    bus_wr(3, 8'h02);
    wait_idle(b);
    check("drop_busy", b, 48);
    idle(2);
    drain("drop", 1);
    do_rd(0, "drop_x");

    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: do_wr(0, ($urandom_range(0, 9) < 8) ?
                    8'($urandom_range(0, 159)) : 8'($urandom_range(160, 255)));
        2: do_wr(1, 8'($urandom_range(0, 127)));
        3, 4: do_wr(2, 8'($urandom_range(0, 255)));
        5: do_wr(3, {7'd0, 1'($urandom_range(0, 1))});
        6: begin
          do_wr(4, 8'($urandom_range(0, 30)));
          do_wr(3, {6'd0, 1'b1, 1'($urandom_range(0, 1))});
        end
        default: do_rd($urandom_range(0, 5), "rnd_rd");
      endcase
      idle(2);
      drain("rnd", 0);
    end

    do_wr(0, 8'd0);
    do_wr(1, 8'd0);
    do_wr(4, 8'd50);
    do_wr(3, 8'h02, 1);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_we", fb_we, 0);
    rst = 1'b0;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    bus_rd(BASE + 8'd5, d);
    check("abort_busy", d, 0);
    idle(5);
    check("abort_nowr", obs_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
